debug_loader: RTL and testbench

Upstream control stage for the pipelined MIPS core. It takes a byte stream from the UART receiver and decodes load, run and step commands. It assembles program bytes into 32-bit instructions and writes them into instruction memory through the core's `i_write`/`i_instruction`/`i_address` port. It then gates the core's `i_enable` for free-running or single-cycle execution until the core reports HALT.

---
 rtl/mips_debug_pkg.sv | 14 +
 rtl/byte_to_word.sv | 31 +++
 rtl/debug_loader.sv | 130 +++++++++++++
 tb/tb_debug_loader.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mips_debug_pkg.sv
// mips_debug_pkg: command bytes, halt word and FSM state encodings shared by the debug loader and the UART TX formatter
package mips_debug_pkg;
    localparam logic [7:0]  CMD_LOAD  = 8'h4C;
    localparam logic [7:0]  CMD_RUN   = 8'h52;
    localparam logic [7:0]  CMD_STEP  = 8'h53;
    localparam logic [31:0] HALT_WORD = 32'h0000_0000;
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_STEP = 3'd3,
        ST_DONE = 3'd4
    } state_t;
endpackage

// File: rtl/byte_to_word.sv
// byte_to_word: packs MSB-first bytes into words; word_valid strobes combinationally on the last byte
module byte_to_word #(
    parameter int NB_BYTE = 8,
    parameter int NB_WORD = 32
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_clear,
    input  logic               i_valid,
    input  logic [NB_BYTE-1:0] i_byte,
    output logic               o_word_valid,
    output logic [NB_WORD-1:0] o_word
);
    logic [1:0]                 cnt_q, cnt_d;
    logic [NB_WORD-NB_BYTE-1:0] shift_q, shift_d;
    assign o_word       = {shift_q, i_byte};
    assign o_word_valid = i_valid && cnt_q == 2'd3;
    always_comb begin
        cnt_d   = i_clear ? 2'd0 : i_valid ? cnt_q + 2'd1 : cnt_q;
        shift_d = i_clear ? '0 : i_valid ? o_word[NB_WORD-NB_BYTE-1:0] : shift_q;
    end
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            cnt_q   <= 2'd0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end
endmodule

// File: rtl/debug_loader.sv
// debug_loader: decodes UART load/run/step commands, writes program words to imem and gates the core enable
module debug_loader
    import mips_debug_pkg::*;
#(
    parameter int                 NB_ADDR   = 32,
    parameter int                 NB_INST   = 32,
    parameter int                 NB_BYTE   = 8,
    parameter int                 MEM_DEPTH = 256,
    parameter logic [NB_ADDR-1:0] START_PC  = '0
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_BYTE-1:0] i_rx_data,
    input  logic               i_rx_valid,
    input  logic               i_halt,
    output logic               o_write,
    output logic [NB_INST-1:0] o_instruction,
    output logic [NB_ADDR-1:0] o_address,
    output logic [NB_ADDR-1:0] o_pc,
    output logic               o_enable,
    output logic               o_error,
    output logic [2:0]         o_state
);
    state_t             state_q, state_d;
    logic               loaded_q, loaded_d;
    logic [NB_ADDR-1:0] index_q, index_d;
    logic               write_q, write_d;
    logic [NB_INST-1:0] inst_q, inst_d;
    logic [NB_ADDR-1:0] addr_q, addr_d;
    logic               enable_q, enable_d;
    logic               error_q, error_d;
    logic               clear, word_valid;
    logic [NB_INST-1:0] word;
    logic               is_load, is_run, is_step;

    byte_to_word #(.NB_BYTE(NB_BYTE), .NB_WORD(NB_INST)) u_b2w (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_clear     (clear),
        .i_valid     (i_rx_valid && state_q == ST_LOAD),
        .i_byte      (i_rx_data),
        .o_word_valid(word_valid),
        .o_word      (word)
    );

    assign is_load = i_rx_data == NB_BYTE'(CMD_LOAD);
    assign is_run  = i_rx_data == NB_BYTE'(CMD_RUN);
    assign is_step = i_rx_data == NB_BYTE'(CMD_STEP);

    always_comb begin
        state_d  = state_q;
        loaded_d = loaded_q;
        index_d  = index_q;
        write_d  = 1'b0;
        inst_d   = inst_q;
        addr_d   = addr_q;
        enable_d = 1'b0;
        error_d  = 1'b0;
        clear    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_rx_valid) begin
                    if (is_load) begin
                        state_d  = ST_LOAD;
                        clear    = 1'b1;
                        index_d  = '0;
                        loaded_d = loaded_q && state_q == ST_IDLE;
                    end else if (state_q == ST_IDLE && loaded_q && (is_run || is_step)) begin
                        state_d  = is_run ? ST_RUN : ST_STEP;
                        enable_d = 1'b1;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (word_valid) begin
                    write_d = 1'b1;
                    inst_d  = word;
                    addr_d  = index_q << 2;
                    index_d = index_q + NB_ADDR'(1);
                    if (word == NB_INST'(HALT_WORD)) begin
                        loaded_d = 1'b1;
                        state_d  = ST_IDLE;
                    end else if (index_q == NB_ADDR'(MEM_DEPTH - 1)) begin
                        // last slot filled without a HALT: program would run off the end
                        error_d = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RUN: begin
                enable_d = !i_halt;
                state_d  = i_halt ? ST_DONE : ST_RUN;
            end
            ST_STEP: state_d = i_halt ? ST_DONE : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q  <= ST_IDLE;
            loaded_q <= 1'b0;
            index_q  <= '0;
            write_q  <= 1'b0;
            inst_q   <= '0;
            addr_q   <= '0;
            enable_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            loaded_q <= loaded_d;
            index_q  <= index_d;
            write_q  <= write_d;
            inst_q   <= inst_d;
            addr_q   <= addr_d;
            enable_q <= enable_d;
            error_q  <= error_d;
        end
    end

    assign o_write       = write_q;
    assign o_instruction = inst_q;
    assign o_address     = addr_q;
    assign o_pc          = START_PC;
    assign o_enable      = enable_q;
    assign o_error       = error_q;
    assign o_state       = state_q;
endmodule

// File: tb/tb_debug_loader.sv
// tb_debug_loader: vector table plus write scoreboard for debug_loader (MEM_DEPTH=4)
module tb_debug_loader;
    logic        i_clk, i_reset, i_rx_valid, i_halt;
    logic [7:0]  i_rx_data;
    logic        o_write, o_enable, o_error;
    logic [31:0] o_instruction, o_address, o_pc;
    logic [2:0]  o_state;
    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] sb_e;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        h;
        logic        err;
        logic        en;
        logic [2:0]  st;
        logic        wr;
        logic [31:0] wa;
        logic [31:0] wd;
    } vec_t;
    vec_t tbl[$];

    debug_loader #(.MEM_DEPTH(4), .START_PC(32'h0)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_rx_data    (i_rx_data),
        .i_rx_valid   (i_rx_valid),
        .i_halt       (i_halt),
        .o_write      (o_write),
        .o_instruction(o_instruction),
        .o_address    (o_address),
        .o_pc         (o_pc),
        .o_enable     (o_enable),
        .o_error      (o_error),
        .o_state      (o_state)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge i_clk) begin
        if (o_write === 1'b1) begin
            if (exp_q.size() == 0) chk("unexpected_write", 32'(o_write), 32'h0);
            else begin
                sb_e = exp_q.pop_front();
                chk("wr_addr", o_address, sb_e[63:32]);
                chk("wr_data", o_instruction, sb_e[31:0]);
            end
        end
    end

    task automatic add(input logic v, input logic [7:0] d, input logic h, input logic err,
                       input logic en, input logic [2:0] st, input logic wr,
                       input logic [31:0] wa, input logic [31:0] wd);
        tbl.push_back('{v, d, h, err, en, st, wr, wa, wd});
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic h);
        i_rx_valid = v;
        i_rx_data  = d;
        i_halt     = h;
        @(negedge i_clk);
    endtask

    task automatic pulse_reset();
        i_reset = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        i_reset = 1'b1;
    endtask

    initial begin
        logic [31:0] w;
        i_reset = 1'b0; i_rx_valid = 1'b0; i_rx_data = 8'h00; i_halt = 1'b0;
        repeat (2) @(negedge i_clk);
        chk("rst_write", 32'(o_write), 32'h0);
        chk("rst_inst", o_instruction, 32'h0);
        chk("rst_addr", o_address, 32'h0);
        chk("rst_enable", 32'(o_enable), 32'h0);
        chk("rst_error", 32'(o_error), 32'h0);
        chk("rst_state", 32'(o_state), 32'h0);
        chk("rst_pc", o_pc, 32'h0);
        i_reset = 1'b1;

        //   v  data   h  err en st    wr addr   data
        add(1, 8'h52, 0, 1, 0, 3'd0, 0, 32'h0, 32'h0);
        add(1, 8'h53, 0, 1, 0, 3'd0, 0, 32'h0, 32'h0);
        add(1, 8'h41, 0, 1, 0, 3'd0, 0, 32'h0, 32'h0);
        add(1, 8'h4C, 0, 0, 0, 3'd1, 0, 32'h0, 32'h0);
        add(1, 8'h00, 0, 0, 0, 3'd1, 0, 32'h0, 32'h0);
        add(1, 8'h22, 0, 0, 0, 3'd1, 0, 32'h0, 32'h0);
        add(1, 8'h20, 0, 0, 0, 3'd1, 0, 32'h0, 32'h0);
        add(1, 8'h20, 0, 0, 0, 3'd1, 1, 32'h0, 32'h00222020);
        add(1, 8'h00, 0, 0, 0, 3'd1, 0, 32'h0, 32'h0);
        add(1, 8'h00, 0, 0, 0, 3'd1, 0, 32'h0, 32'h0);
        add(1, 8'h00, 0, 0, 0, 3'd1, 0, 32'h0, 32'h0);
        add(1, 8'h00, 0, 0, 0, 3'd0, 1, 32'h4, 32'h0);
        add(1, 8'h53, 0, 0, 1, 3'd3, 0, 32'h0, 32'h0);
        add(0, 8'h00, 0, 0, 0, 3'd0, 0, 32'h0, 32'h0);
        add(1, 8'h52, 0, 0, 1, 3'd2, 0, 32'h0, 32'h0);
        add(0, 8'h00, 0, 0, 1, 3'd2, 0, 32'h0, 32'h0);
        add(1, 8'h41, 0, 0, 1, 3'd2, 0, 32'h0, 32'h0);
        add(1, 8'h4C, 1, 0, 0, 3'd4, 0, 32'h0, 32'h0);
        add(0, 8'h00, 1, 0, 0, 3'd4, 0, 32'h0, 32'h0);
        add(1, 8'h52, 0, 1, 0, 3'd4, 0, 32'h0, 32'h0);
        add(0, 8'h00, 0, 0, 0, 3'd4, 0, 32'h0, 32'h0);
        add(1, 8'h4C, 0, 0, 0, 3'd1, 0, 32'h0, 32'h0);
        add(1, 8'h00, 0, 0, 0, 3'd1, 0, 32'h0, 32'h0);
        add(1, 8'h00, 0, 0, 0, 3'd1, 0, 32'h0, 32'h0);
        add(1, 8'h00, 0, 0, 0, 3'd1, 0, 32'h0, 32'h0);
        add(1, 8'h00, 0, 0, 0, 3'd0, 1, 32'h0, 32'h0);
        add(1, 8'h53, 0, 0, 1, 3'd3, 0, 32'h0, 32'h0);
        add(0, 8'h00, 1, 0, 0, 3'd4, 0, 32'h0, 32'h0);
        add(0, 8'h00, 0, 0, 0, 3'd4, 0, 32'h0, 32'h0);

        foreach (tbl[i]) begin
            if (tbl[i].wr) exp_q.push_back({tbl[i].wa, tbl[i].wd});
            drive(tbl[i].v, tbl[i].d, tbl[i].h);
            chk($sformatf("vec%0d_error", i), 32'(o_error), 32'(tbl[i].err));
            chk($sformatf("vec%0d_enable", i), 32'(o_enable), 32'(tbl[i].en));
            chk($sformatf("vec%0d_state", i), 32'(o_state), 32'(tbl[i].st));
            chk($sformatf("vec%0d_write", i), 32'(o_write), 32'(tbl[i].wr));
        end

        // reset in the middle of a word: partial bytes must be dropped
        drive(1'b1, 8'h4C, 1'b0);
        drive(1'b1, 8'h11, 1'b0);
        drive(1'b1, 8'h22, 1'b0);
        pulse_reset();
        chk("midrst_state", 32'(o_state), 32'h0);
        chk("midrst_write", 32'(o_write), 32'h0);
        chk("midrst_inst", o_instruction, 32'h0);
        drive(1'b1, 8'h4C, 1'b0);
        drive(1'b1, 8'hAA, 1'b0);
        drive(1'b1, 8'hBB, 1'b0);
        drive(1'b1, 8'hCC, 1'b0);
        exp_q.push_back({32'h0, 32'hAABBCCDD});
        drive(1'b1, 8'hDD, 1'b0);
        chk("reload_write0", 32'(o_write), 32'h1);
        repeat (3) drive(1'b1, 8'h00, 1'b0);
        exp_q.push_back({32'h4, 32'h0});
        drive(1'b1, 8'h00, 1'b0);
        chk("reload_state", 32'(o_state), 32'h0);

        // overflow: four non-HALT words into a four-word memory
        pulse_reset();
        drive(1'b1, 8'h4C, 1'b0);
        for (int k = 0; k < 4; k++) begin
            w = 32'h11111111 * (k + 1);
            drive(1'b1, w[31:24], 1'b0);
            drive(1'b1, w[23:16], 1'b0);
            drive(1'b1, w[15:8], 1'b0);
            exp_q.push_back({32'(k * 4), w});
            drive(1'b1, w[7:0], 1'b0);
            chk($sformatf("ovf_err%0d", k), 32'(o_error), (k == 3) ? 32'h1 : 32'h0);
            chk($sformatf("ovf_state%0d", k), 32'(o_state), (k == 3) ? 32'h0 : 32'h1);
        end
        drive(1'b1, 8'h52, 1'b0);
        chk("ovf_run_err", 32'(o_error), 32'h1);
        chk("ovf_run_en", 32'(o_enable), 32'h0);
        drive(1'b0, 8'h00, 1'b0);
        chk("ovf_run_state", 32'(o_state), 32'h0);

        chk("sb_drain", exp_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
